// File: rtl/wb_ooo_slave_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_ooo_slave_mem : tagged Wishbone slave memory with out-of-order replies |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wb_ooo_slave_mem #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256,
  parameter int BASE_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [63:0] ADR_I,
  input  logic [63:0] DAT_I,
  input  logic [7:0]  SEL_I,
  input  logic [15:0] TGA_I,
  input  logic        RST_I,
  input  logic        LOCK_I,
  input  logic [15:0] TGC_I,
  input  logic [15:0] TGD_I,
  output logic        RESP_O,
  output logic        RTY_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [63:0] DAT_O,
  output logic [15:0] TGD_O
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(BASE_LAT + 4);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]      mem_q [MEM_WORDS];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] err_q, err_d;
  logic [DEPTH-1:0] we_q, we_d;
  logic [15:0]      tag_q   [DEPTH];
  logic [15:0]      tag_d   [DEPTH];
  logic [63:0]      rdata_q [DEPTH];
  logic [63:0]      rdata_d [DEPTH];
  logic [CW-1:0]    cnt_q   [DEPTH];
  logic [CW-1:0]    cnt_d   [DEPTH];

  logic             resp_q, resp_d;
  logic             rty_q, rty_d;
  logic             ack_q, ack_d;
  logic             err_o_q, err_o_d;
  logic [63:0]      dat_q, dat_d;
  logic [15:0]      tgd_q, tgd_d;

  logic             offer;
  logic             full;
  logic             accept;
  logic             in_range;
  logic [AW-1:0]    widx;
  logic [CW-1:0]    lat_m1;
  logic [63:0]      wmask;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    rdy_idx;
  logic             any_ready;
  logic             unused_ok;

  assign unused_ok = ^{LOCK_I, TGC_I, TGD_I, ADR_I[2:0]};

  // The ~RESP_O/~RTY_O terms stop a still-asserted STB_I being taken twice.
  assign offer    = CYC_I & STB_I & ~resp_q & ~rty_q;
  assign full     = &valid_q;
  assign accept   = offer & ~full & ~RST_I;
  assign in_range = ~|ADR_I[63:3+AW];
  assign widx     = ADR_I[3+AW-1:3];
  // Counter holds remaining cycles minus one, so a zero count at edge N+L-1
  // lets the arbiter register the reply at edge N+L.
  assign lat_m1   = CW'(BASE_LAT - 1) + CW'(ADR_I[4:3]);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 8; b++) begin
      wmask[8*b +: 8] = {8{SEL_I[b]}};
    end
  end

  always_comb begin
    free_idx  = '0;
    rdy_idx   = '0;
    any_ready = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IW'(i);
      end
      if (valid_q[i] && (cnt_q[i] == '0)) begin
        any_ready = 1'b1;
        rdy_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    we_d    = we_q;
    tag_d   = tag_q;
    rdata_d = rdata_q;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? (cnt_q[i] - CW'(1)) : cnt_q[i];
    end
    if (any_ready) begin
      valid_d[rdy_idx] = 1'b0;
    end
    if (accept) begin
      valid_d[free_idx] = 1'b1;
      err_d[free_idx]   = ~in_range;
      we_d[free_idx]    = WE_I;
      tag_d[free_idx]   = TGA_I;
      rdata_d[free_idx] = (in_range && !WE_I) ? mem_q[widx] : 64'd0;
      cnt_d[free_idx]   = lat_m1;
    end
    if (RST_I) begin
      valid_d = '0;
    end
  end

  always_comb begin
    resp_d  = accept;
    rty_d   = offer & full & ~RST_I;
    ack_d   = any_ready & ~err_q[rdy_idx] & ~RST_I;
    err_o_d = any_ready & err_q[rdy_idx] & ~RST_I;
    dat_d   = ack_d ? rdata_q[rdy_idx] : 64'd0;
    tgd_d   = (ack_d | err_o_d) ? tag_q[rdy_idx] : 16'd0;
  end

  // Memory has no reset; contents survive both rst and RST_I.
  always_ff @(posedge clk) begin
    if (accept && WE_I && in_range && rst) begin
      mem_q[widx] <= (mem_q[widx] & ~wmask) | (DAT_I & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      err_q   <= '0;
      we_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]   <= '0;
        rdata_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      resp_q  <= 1'b0;
      rty_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_o_q <= 1'b0;
      dat_q   <= '0;
      tgd_q   <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      we_q    <= we_d;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]   <= tag_d[i];
        rdata_q[i] <= rdata_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      resp_q  <= resp_d;
      rty_q   <= rty_d;
      ack_q   <= ack_d;
      err_o_q <= err_o_d;
      dat_q   <= dat_d;
      tgd_q   <= tgd_d;
    end
  end

  assign RESP_O = resp_q;
  assign RTY_O  = rty_q;
  assign ACK_O  = ack_q;
  assign ERR_O  = err_o_q;
  assign DAT_O  = dat_q;
  assign TGD_O  = tgd_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_ooo_slave_mem.sv
`default_nettype none
// tb_wb_ooo_slave_mem: directed + random stimulus, scoreboard against a
// cycle-counted reference model of the out-of-order slave memory.
module tb_wb_ooo_slave_mem;

  localparam int DEPTH     = 2;
  localparam int MEM_WORDS = 256;
  localparam int BASE_LAT  = 2;
  localparam int AW        = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CYC_I, STB_I, WE_I, RST_I, LOCK_I;
  logic [63:0] ADR_I, DAT_I;
  logic [7:0]  SEL_I;
  logic [15:0] TGA_I, TGC_I, TGD_I;
  logic        RESP_O, RTY_O, ACK_O, ERR_O;
  logic [63:0] DAT_O;
  logic [15:0] TGD_O;

  always #5 clk = ~clk;

  wb_ooo_slave_mem #(
    .DEPTH     (DEPTH),
    .MEM_WORDS (MEM_WORDS),
    .BASE_LAT  (BASE_LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .CYC_I  (CYC_I),
    .STB_I  (STB_I),
    .WE_I   (WE_I),
    .ADR_I  (ADR_I),
    .DAT_I  (DAT_I),
    .SEL_I  (SEL_I),
    .TGA_I  (TGA_I),
    .RST_I  (RST_I),
    .LOCK_I (LOCK_I),
    .TGC_I  (TGC_I),
    .TGD_I  (TGD_I),
    .RESP_O (RESP_O),
    .RTY_O  (RTY_O),
    .ACK_O  (ACK_O),
    .ERR_O  (ERR_O),
    .DAT_O  (DAT_O),
    .TGD_O  (TGD_O)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] tag;
    logic [63:0] data;
  } comp_t;

  typedef struct {
    int   cyc;
    logic rty;
  } hs_t;

  comp_t exp_q[$];
  hs_t   hs_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;

  // Reference model state: a word array and a set of pending requests,
  // each with the absolute cycle from which it may complete.
  logic [63:0] mmem  [MEM_WORDS];
  bit          m_val [DEPTH];
  int          m_rdy [DEPTH];
  logic        m_err [DEPTH];
  logic [15:0] m_tag [DEPTH];
  logic [63:0] m_dat [DEPTH];
  bit          m_resp, m_rty;

  task automatic model_step();
    bit    offer, full, inr;
    int    fr, pick, idx, lat;
    comp_t c;
    hs_t   h;
    offer = CYC_I && STB_I && !m_resp && !m_rty;
    full  = 1'b1;
    fr    = -1;
    pick  = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_val[i]) begin
        full = 1'b0;
        if (fr < 0) fr = i;
      end
      if (m_val[i] && (m_rdy[i] <= cycle) && (pick < 0)) pick = i;
    end
    if (pick >= 0) begin
      c.cyc  = cycle;
      c.err  = m_err[pick];
      c.tag  = m_tag[pick];
      c.data = m_dat[pick];
      exp_q.push_back(c);
      m_val[pick] = 1'b0;
    end
    m_resp = 1'b0;
    m_rty  = 1'b0;
    if (offer) begin
      h.cyc = cycle;
      h.rty = full;
      hs_q.push_back(h);
      if (full) begin
        m_rty = 1'b1;
      end else begin
        inr = ((ADR_I >> (3 + AW)) == 64'd0);
        idx = int'((ADR_I >> 3) % 64'(MEM_WORDS));
        lat = BASE_LAT + int'((ADR_I >> 3) % 64'd4);
        m_val[fr] = 1'b1;
        m_rdy[fr] = cycle + lat;
        m_err[fr] = !inr;
        m_tag[fr] = TGA_I;
        m_dat[fr] = 64'd0;
        if (inr && WE_I) begin
          for (int b = 0; b < 8; b++)
            if (SEL_I[b]) mmem[idx][8*b +: 8] = DAT_I[8*b +: 8];
        end else if (inr) begin
          m_dat[fr] = mmem[idx];
        end
        m_resp = 1'b1;
      end
    end
  endtask

  initial begin : model
    for (int i = 0; i < MEM_WORDS; i++) mmem[i] = 64'd0;
    for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
    m_resp = 1'b0;
    m_rty  = 1'b0;
    forever begin
      @(posedge clk);
      cycle++;
      if (!rst || RST_I) begin
        for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
        m_resp = 1'b0;
        m_rty  = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  initial begin : monitor
    comp_t e;
    hs_t   h;
    bit    ok;
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cycle) begin
        e  = exp_q.pop_front();
        ok = (ACK_O == !e.err) && (ERR_O == e.err) && (TGD_O == e.tag) && (DAT_O == e.data);
        if (!ok) begin
          errors++;
          $display("FAIL completion @%0d: got ack=%0b err=%0b tag=%h dat=%h, expected ack=%0b err=%0b tag=%h dat=%h",
                   cycle, ACK_O, ERR_O, TGD_O, DAT_O, !e.err, e.err, e.tag, e.data);
        end
      end else if (ACK_O || ERR_O || DAT_O != 64'd0 || TGD_O != 16'd0) begin
        errors++;
        $display("FAIL idle_reply @%0d: got ack=%0b err=%0b tag=%h dat=%h, expected all zero",
                 cycle, ACK_O, ERR_O, TGD_O, DAT_O);
      end
      checks++;
      if (hs_q.size() > 0 && hs_q[0].cyc == cycle) begin
        h = hs_q.pop_front();
        if (RESP_O != !h.rty || RTY_O != h.rty) begin
          errors++;
          $display("FAIL handshake @%0d: got resp=%0b rty=%0b, expected resp=%0b rty=%0b",
                   cycle, RESP_O, RTY_O, !h.rty, h.rty);
        end
      end else if (RESP_O || RTY_O) begin
        errors++;
        $display("FAIL idle_handshake @%0d: got resp=%0b rty=%0b, expected 0 0", cycle, RESP_O, RTY_O);
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if (RESP_O || RTY_O || ACK_O || ERR_O || DAT_O != 64'd0 || TGD_O != 16'd0) begin
      errors++;
      $display("FAIL %s: got resp=%0b rty=%0b ack=%0b err=%0b dat=%h tag=%h, expected all zero",
               nm, RESP_O, RTY_O, ACK_O, ERR_O, DAT_O, TGD_O);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                       input logic [7:0] sel, input logic [15:0] tag);
    @(negedge clk);
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = we;
    ADR_I = adr;
    DAT_I = dat;
    SEL_I = sel;
    TGA_I = tag;
    @(negedge clk);
    CYC_I = 1'b0;
    STB_I = 1'b0;
  endtask

  initial begin : stim
    logic [63:0] one;
    one    = 64'd1;
    CYC_I  = 1'b0;
    STB_I  = 1'b0;
    WE_I   = 1'b0;
    ADR_I  = '0;
    DAT_I  = '0;
    SEL_I  = '0;
    TGA_I  = '0;
    RST_I  = 1'b0;
    LOCK_I = 1'b0;
    TGC_I  = '0;
    TGD_I  = '0;

    #1 rst = 1'b0;
    #2 check_zero("reset_state");
    idle(3);
    #2 rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 64'(i * 8), {$urandom, $urandom}, 8'hFF, 16'(16'h0100 + i));
      idle(6);
    end

    offer(1'b1, 64'h0, 64'h1122334455667788, 8'hFF, 16'h000A);
    idle(6);
    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0001);
    offer(1'b0, 64'h0, 64'd0, 8'h00, 16'h0002);
    idle(8);

    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0021);
    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0022);
    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0023);
    idle(4);
    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0023);
    idle(8);

    offer(1'b1, 64'h8, 64'd0, 8'hFF, 16'h0003);
    idle(6);
    offer(1'b1, 64'h8, '1, 8'h0F, 16'h0004);
    idle(6);
    offer(1'b0, 64'h8, 64'd0, 8'h00, 16'h0005);
    idle(6);

    offer(1'b1, 64'h800, '1, 8'hFF, 16'h0007);
    idle(6);
    offer(1'b0, 64'h0, 64'd0, 8'h00, 16'h0008);
    idle(6);

    offer(1'b0, 64'h10, 64'd0, 8'h00, 16'h0031);
    offer(1'b0, 64'h0, 64'd0, 8'h00, 16'h0032);
    idle(8);
    offer(1'b0, 64'h0, 64'd0, 8'h00, 16'h0033);
    offer(1'b0, 64'h0, 64'd0, 8'h00, 16'h0034);
    idle(8);

    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0041);
    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0042);
    #2 rst = 1'b0;
    #1 check_zero("async_reset_clears");
    @(negedge clk);
    #2 rst = 1'b1;
    idle(10);

    offer(1'b0, 64'h18, 64'd0, 8'h00, 16'h0051);
    @(negedge clk);
    RST_I = 1'b1;
    @(negedge clk);
    RST_I = 1'b0;
    idle(10);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      CYC_I = ($urandom_range(0, 3) != 0);
      STB_I = ($urandom_range(0, 2) != 0);
      WE_I  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        ADR_I = (one << $urandom_range(3 + AW, 63)) | 64'($urandom_range(0, 63));
      else
        ADR_I = 64'($urandom_range(0, 63));
      DAT_I = {$urandom, $urandom};
      SEL_I = 8'($urandom);
      TGA_I = 16'($urandom);
      RST_I = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    RST_I = 1'b0;
    idle(20);

    checks++;
    if (exp_q.size() != 0 || hs_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d replies and %0d handshakes pending, expected 0 and 0",
               exp_q.size(), hs_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
